// File: rtl/dm_bytewise.sv
// Byte-addressable data memory: byte/half/word stores with lane enables,
// sign/zero-extended sub-word loads, registered reads, post-reset clear.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   req, we, size    access request, store/load, 00 byte 01 half 10 word
//   sign_ext         sub-word load extension select
//   addr, din        byte address, right-justified store data
//   ready            access accepted on the next edge when req=1
//   rvalid, dout     one-cycle load result (dout=0 otherwise)
//   err              one-cycle pulse for a misaligned/illegal access
//   busy             clear sequence in progress
module dm_bytewise #(
  parameter int WORDS_LOG2     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [WORDS_LOG2+1:0] addr,
  input  logic [31:0]           din,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           dout,
  output logic                  err,
  output logic                  busy
);

  localparam int DEPTH = 1 << WORDS_LOG2;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                state;
  logic [WORDS_LOG2-1:0] cnt;
  logic [31:0]           mem [DEPTH];

  logic [WORDS_LOG2-1:0] widx;
  logic [WORDS_LOG2-1:0] wsel;
  logic [1:0]            lane;
  logic                  legal;
  logic                  accept;
  logic                  st;
  logic                  ld;
  logic                  clr;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [31:0]           rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [31:0]           ldata;

  assign widx   = addr[WORDS_LOG2+1:2];
  assign lane   = addr[1:0];
  // ready is only ever 1 in IDLE, so it doubles as the accept gate
  assign accept = ready & req;
  assign st     = accept & we & legal;
  assign ld     = accept & ~we & legal;
  // clear writes must not happen while reset is held
  assign clr    = (state == S_CLEAR) & rst_n;

  always_comb begin
    legal = 1'b0;
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (lane == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    wmask = 4'b0000;
    wdata = din;
    wsel  = widx;
    case (size)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wdata = {4{din[7:0]}};
      end
      2'b01: begin
        wmask = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = din;
      end
    endcase
    if (clr) begin
      wmask = 4'b1111;
      wdata = '0;
      wsel  = cnt;
    end else if (!st) begin
      wmask = 4'b0000;
    end
  end

  // array has no reset; contents survive rst_n
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wmask[k]) mem[wsel][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rword = mem[widx];
  assign rbyte = rword[8*lane +: 8];
  assign rhalf = rword[16*addr[1] +: 16];

  always_comb begin
    ldata = rword;
    case (size)
      2'b00:   ldata = {{24{sign_ext & rbyte[7]}}, rbyte};
      2'b01:   ldata = {{16{sign_ext & rhalf[15]}}, rhalf};
      default: ldata = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      busy   <= CLEAR_ON_RESET;
      rvalid <= 1'b0;
      err    <= 1'b0;
      dout   <= '0;
    end else begin
      rvalid <= ld;
      err    <= accept & ~legal;
      dout   <= ld ? ldata : 32'd0;
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {WORDS_LOG2{1'b1}}) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_bytewise.md
Name: dm_bytewise

Overview:
- Parametrised successor to the 4 KB word-only data memory for the single-cycle/multi-cycle MIPS datapath.
- Adds byte/halfword/word stores with lane enables, and sign- or zero-extended sub-word loads.
- Registered reads with a valid pulse, a req/ready handshake, alignment error reporting, and an optional post-reset clear sequencer that zeroes the array.
- Sits between the datapath MEM stage and the memory array.

Parameters:
- WORDS_LOG2, 10, log2 of depth in 32-bit words; default gives 4 KB.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = go straight to IDLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  access request, sampled on a clk edge while ready=1
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  input  1  loads only: 1 = sign-extend sub-word, 0 = zero-extend
- addr  input  WORDS_LOG2+2  byte address
- din  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- ready  output  1  block can accept req this cycle
- rvalid  output  1  one-cycle pulse: dout holds load result
- dout  output  32  load result; 0 when rvalid=0
- err  output  1  one-cycle pulse: previous accepted access was misaligned or illegal
- busy  output  1  clear sequence in progress

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ready=0, rvalid=0, err=0, dout=0.
  - busy=CLEAR_ON_RESET.
  - Clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - Array contents are not touched by reset itself.
- Reset mid-CLEAR or mid-access: all of the above apply; clearing restarts at word 0; a pending rvalid/err is dropped.
- State CLEAR:
  - Writes 0 to word[cnt] each cycle; cnt increments.
  - After word 2^WORDS_LOG2-1 is written: state goes to IDLE, busy drops to 0, ready rises to 1 on the same edge.
  - Clear takes exactly 2^WORDS_LOG2 cycles after rst_n rises.
  - req is ignored in CLEAR.
- State IDLE:
  - ready=1.
  - An access is accepted on any edge with req=1.
  - One access per cycle, back-to-back allowed.
  - No other states.
- Byte lanes: little-endian; lane k = bits [8k+7:8k]; addr[1:0] selects the lane; word index = addr[WORDS_LOG2+1:2].
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - size=11 is always illegal.
  - Violation: no array write and rvalid=0 on the next cycle; err=1 for one cycle after the accepting edge.
- Store (we=1, legal):
  - Array updated at the accepting edge; only the selected lanes change.
  - Byte: din[7:0] goes to lane addr[1:0].
  - Half: din[15:0] goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Word: all four lanes written.
  - rvalid stays 0; err stays 0.
- Load (we=0, legal):
  - Data sampled at the accepting edge; rvalid=1 and dout valid for exactly the following cycle.
  - Latency 1.
  - Byte/half results are extended per sign_ext; word ignores sign_ext.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. A load and a store cannot be accepted on the same edge (single port).
- Address wrap: the address width exactly covers the array; no out-of-range case exists.
- No X propagation: dout is forced to 0 whenever rvalid=0.

Test Plan:
- Clear with WORDS_LOG2=4, CLEAR_ON_RESET=1:
  - Release rst_n, hold req=1 -> busy=1 and ready=0 for exactly 16 cycles.
  - No rvalid during clear.
  - Then loading word at 0x3C -> rvalid next cycle, dout=0x00000000.
- Sub-word stores and loads:
  - SW 0x11223344 @0x10, then SB 0xAA @0x11, then SH 0xBEEF @0x12.
  - LW @0x10 -> dout=0xBEEFAA44.
  - LB sign_ext=1 @0x11 -> 0xFFFFFFAA.
  - LHU @0x12 -> 0x0000BEEF.
- Back-to-back:
  - SW 0xCAFEF00D @0x20 then LW @0x20 on the next edge -> rvalid=1 one cycle later with 0xCAFEF00D.
  - Three consecutive loads give three consecutive rvalid pulses.
- Misalignment:
  - SH @0x21 -> err=1 for one cycle, rvalid=0.
  - LW @0x20 afterwards still returns 0xCAFEF00D.
  - size=11 @0x00 -> err=1.
- Reset mid-clear:
  - Pull rst_n low at clear cycle 7 -> ready, busy and outputs asynchronously go to reset values.
  - After release, busy is high for a full 16 cycles again.
- CLEAR_ON_RESET=0: ready=1 on the first edge after reset release; a load accepted there gives rvalid on the next cycle.
